uart_frame_receiver: RTL and testbench

Parametrised UART receiver for the test harness. It turns the host-to-FPGA serial line (`uart_receive`) into framed data words on a valid/ready stream. Frame format is configurable: data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and the block reports per-frame parity and framing errors plus a one-cycle overrun pulse.

---
 rtl/uart_frame_receiver_if.sv | 40 ++++
 rtl/uart_frame_receiver.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_frame_receiver_if
//
// Output stream of the UART frame receiver: one received word plus its
// per-frame error flags, qualified by a valid/ready handshake.
//
//   data_out        word received, LSB of the frame first on the line
//   data_out_valid  data_out and both error flags are valid
//   data_out_ready  consumer accepts the word at this clock edge
//   parity_error    held frame failed its parity check
//   framing_error   a stop bit of the held frame was sampled low
//
// master : the receiver (drives word, valid and flags)
// slave  : the consumer (drives ready)
// ---------------------------------------------------------------------------
interface uart_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 parity_error;
    logic                 framing_error;

    modport master (
        output data_out,
        output data_out_valid,
        output parity_error,
        output framing_error,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  parity_error,
        input  framing_error,
        output data_out_ready
    );
endinterface

// File: rtl/uart_frame_receiver.sv
// ---------------------------------------------------------------------------
// uart_frame_receiver
//
// UART receiver turning the asynchronous serial line into framed words on
// a valid/ready stream. Frame: 1 start bit, DATA_BITS data bits (LSB
// first), optional parity bit, STOP_BITS stop bits. Every bit cell is
// decided by a 3-sample majority vote around the cell centre.
//
// Ports:
//   clock         single clock
//   reset         synchronous, active-high
//   uart_receive  asynchronous serial input, idles high
//   stream        master side of the output stream (word + error flags)
//   overrun       one-cycle pulse when a completed frame had to be dropped
//   busy          receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_frame_receiver #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   uart_receive,
    uart_frame_receiver_if.master  stream,
    output logic                   overrun,
    output logic                   busy
);

    localparam int CPB         = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF        = CPB / 2;
    localparam int CW          = $clog2(CPB);
    localparam int IW          = $clog2(DATA_BITS);
    localparam int SYNC_STAGES = 2;

    localparam logic [CW-1:0] CNT_LAST   = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_SAMP0  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_SAMP1  = CW'(HALF);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF + 1);
    localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] settle_reg;
    logic                   rx_s;
    logic                   rx_prev_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) begin
                        sync_reg[gi]   <= 1'b1;
                        settle_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi]   <= uart_receive;
                        settle_reg[gi] <= 1'b1;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (reset) begin
                        sync_reg[gi]   <= 1'b1;
                        settle_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi]   <= sync_reg[gi-1];
                        settle_reg[gi] <= settle_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t                state_reg;
    state_t                state_next;
    logic [CW-1:0]         count_reg;
    logic [1:0]            sample_reg;
    logic [IW-1:0]         bit_idx_reg;
    logic                  stop_idx_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  parity_acc_reg;
    logic                  parity_bad_reg;
    logic                  frame_bad_reg;

    logic [DATA_BITS-1:0]  data_reg;
    logic                  valid_reg;
    logic                  parity_error_reg;
    logic                  framing_error_reg;
    logic                  overrun_reg;

    logic                  start_edge;
    logic                  cell_end;
    logic                  decide;
    logic                  majority;
    logic                  complete;
    logic                  transfer;
    logic                  parity_sum;

    assign start_edge = !rx_s && rx_prev_reg;
    assign cell_end   = (count_reg == CNT_LAST);
    assign decide     = (count_reg == CNT_DECIDE);
    assign majority   = (sample_reg[0] & sample_reg[1]) |
                        (sample_reg[0] & rx_s) |
                        (sample_reg[1] & rx_s);
    assign transfer   = valid_reg && stream.data_out_ready;
    assign parity_sum = parity_acc_reg ^ majority;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // A high majority at the start-cell centre was a glitch.
                if (decide && majority) begin
                    state_next = ST_IDLE;
                end else if (cell_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cell_end && (bit_idx_reg == BIT_LAST)) begin
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (cell_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish at the centre of the last stop cell so the next
                // start edge can arrive half a cell later.
                if (decide && (stop_idx_reg == STOP_LAST)) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev_reg       <= 1'b0;
            state_reg         <= ST_IDLE;
            count_reg         <= '0;
            sample_reg        <= '0;
            bit_idx_reg       <= '0;
            stop_idx_reg      <= 1'b0;
            shift_reg         <= '0;
            parity_acc_reg    <= 1'b0;
            parity_bad_reg    <= 1'b0;
            frame_bad_reg     <= 1'b0;
            data_reg          <= '0;
            valid_reg         <= 1'b0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            // The synchroniser's reset value is not a real observation of
            // the line, so the edge register only tracks rx_s once the
            // pin value has reached it. A line held low across reset
            // therefore cannot produce a start edge.
            rx_prev_reg <= settle_reg[SYNC_STAGES-1] & rx_s;
            state_reg   <= state_next;

            if (state_reg == ST_IDLE) begin
                count_reg <= start_edge ? CW'(1) : '0;
            end else begin
                count_reg <= cell_end ? '0 : count_reg + CW'(1);
            end

            if (count_reg == CNT_SAMP0) begin
                sample_reg[0] <= rx_s;
            end
            if (count_reg == CNT_SAMP1) begin
                sample_reg[1] <= rx_s;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        bit_idx_reg    <= '0;
                        stop_idx_reg   <= 1'b0;
                        parity_acc_reg <= 1'b0;
                        parity_bad_reg <= 1'b0;
                        frame_bad_reg  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift_reg      <= {majority, shift_reg[DATA_BITS-1:1]};
                        parity_acc_reg <= parity_sum;
                    end
                    if (cell_end) begin
                        bit_idx_reg <= bit_idx_reg + IW'(1);
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        // Odd parity wants a total XOR of 1, even wants 0.
                        parity_bad_reg <= (PARITY == 1) ? !parity_sum : parity_sum;
                    end
                end
                ST_STOP: begin
                    if (decide && !majority) begin
                        frame_bad_reg <= 1'b1;
                    end
                    if (cell_end) begin
                        stop_idx_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Output holding register: a completed frame replaces the held
            // word only if the slot is empty or being emptied this cycle.
            overrun_reg <= 1'b0;
            if (complete) begin
                if (!valid_reg || transfer) begin
                    data_reg          <= shift_reg;
                    parity_error_reg  <= (PARITY != 0) && parity_bad_reg;
                    framing_error_reg <= frame_bad_reg | !majority;
                    valid_reg         <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (transfer) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign stream.data_out       = data_reg;
    assign stream.data_out_valid = valid_reg;
    assign stream.parity_error   = parity_error_reg;
    assign stream.framing_error  = framing_error_reg;
    assign overrun               = overrun_reg;
    assign busy                  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_receiver
//
// Four receivers share one clock and reset, each with its own serial line:
//   dut0 8N1, dut1 8E1, dut2 8O1, dut3 7N2  (CPB = 10, HALF = 5).
// Expected words are queued when a frame is driven and checked when the
// receiver hands the word over.
// ---------------------------------------------------------------------------
module tb_uart_frame_receiver;

    localparam int CPB = 10;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] rx_line;
    wire  [3:0] overrun_w;
    wire  [3:0] busy_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc0 = 0;
    logic prev_v0 = 1'b0;
    int ovr_cnt0 = 0;
    int ovr_snap;
    int lat;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_frame_receiver_if #(.DATA_BITS(8)) bus0 ();
    uart_frame_receiver_if #(.DATA_BITS(8)) bus1 ();
    uart_frame_receiver_if #(.DATA_BITS(8)) bus2 ();
    uart_frame_receiver_if #(.DATA_BITS(7)) bus3 ();

    uart_frame_receiver #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .uart_receive(rx_line[0]),
        .stream(bus0), .overrun(overrun_w[0]), .busy(busy_w[0]));
    uart_frame_receiver #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_BITS(8),
                          .PARITY(2), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .uart_receive(rx_line[1]),
        .stream(bus1), .overrun(overrun_w[1]), .busy(busy_w[1]));
    uart_frame_receiver #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_BITS(8),
                          .PARITY(1), .STOP_BITS(1)) dut2 (
        .clock(clock), .reset(reset), .uart_receive(rx_line[2]),
        .stream(bus2), .overrun(overrun_w[2]), .busy(busy_w[2]));
    uart_frame_receiver #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_BITS(7),
                          .PARITY(0), .STOP_BITS(2)) dut3 (
        .clock(clock), .reset(reset), .uart_receive(rx_line[3]),
        .stream(bus3), .overrun(overrun_w[3]), .busy(busy_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int idx, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic take(input int idx, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        int   sz;
        case (idx)
            0:       sz = q0.size();
            1:       sz = q1.size();
            2:       sz = q2.size();
            default: sz = q3.size();
        endcase
        n_checks++;
        assert (sz > 0) else begin
            n_fail++;
            $error("FAIL unexpected_word dut%0d: observed data %0h, required no word", idx, d);
        end
        if (sz > 0) begin
            case (idx)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                2:       e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            $display("dut%0d word %0h pe=%0b fe=%0b (expected %0h pe=%0b fe=%0b)",
                     idx, d, pe, fe, e.data, e.pe, e.fe);
            check($sformatf("data dut%0d", idx), 32'(d), 32'(e.data));
            check($sformatf("parity_error dut%0d", idx), 32'(pe), 32'(e.pe));
            check($sformatf("framing_error dut%0d", idx), 32'(fe), 32'(e.fe));
        end
    endtask

    // Parity flag model: mode 1 = odd (XOR must be 1), mode 2 = even (XOR must be 0).
    function automatic logic exp_pe(input int mode, input logic [8:0] d, input logic pb);
        logic x;
        x = pb;
        for (int i = 0; i < 8; i++) x = x ^ d[i];
        return (mode == 1) ? !x : x;
    endfunction

    // Drives one frame on line idx starting at a falling clock edge.
    task automatic send_frame(input int idx, input logic [8:0] data, input int nd,
                              input int has_par, input logic pbit, input int ns,
                              input logic stop_val);
        logic [15:0] bits;
        int n;
        bits    = '0;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (has_par != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = stop_val;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            rx_line[idx] = bits[b];
            if (b == 0) fall_cyc = cyc;
            repeat (CPB) @(negedge clock);
        end
        rx_line[idx] = 1'b1;
    endtask

    // Handshake monitors
    always @(negedge clock)
        if (!reset && bus0.data_out_valid && bus0.data_out_ready)
            take(0, 9'(bus0.data_out), bus0.parity_error, bus0.framing_error);
    always @(negedge clock)
        if (!reset && bus1.data_out_valid && bus1.data_out_ready)
            take(1, 9'(bus1.data_out), bus1.parity_error, bus1.framing_error);
    always @(negedge clock)
        if (!reset && bus2.data_out_valid && bus2.data_out_ready)
            take(2, 9'(bus2.data_out), bus2.parity_error, bus2.framing_error);
    always @(negedge clock)
        if (!reset && bus3.data_out_valid && bus3.data_out_ready)
            take(3, 9'(bus3.data_out), bus3.parity_error, bus3.framing_error);

    always @(negedge clock) begin
        if (bus0.data_out_valid && !prev_v0) rise_cyc0 <= cyc;
        prev_v0 <= bus0.data_out_valid;
        if (overrun_w[0]) ovr_cnt0 <= ovr_cnt0 + 1;
    end

    initial begin
        rx_line = 4'hF;
        reset   = 1'b1;
        bus0.data_out_ready = 1'b1;
        bus1.data_out_ready = 1'b1;
        bus2.data_out_ready = 1'b1;
        bus3.data_out_ready = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("reset valid dut0", 32'(bus0.data_out_valid), 32'(0));
        check("reset data dut0", 32'(bus0.data_out), 32'(0));
        check("reset busy", 32'(busy_w), 32'(0));
        check("reset overrun", 32'(overrun_w), 32'(0));
        check("reset flags dut3", 32'({bus3.parity_error, bus3.framing_error}), 32'(0));
        repeat (5) @(negedge clock);

        // 8N1 stream, back to back
        ovr_snap = ovr_cnt0;
        push(0, 9'h48, 1'b0, 1'b0);
        send_frame(0, 9'h48, 8, 0, 1'b0, 1, 1'b1);
        lat = rise_cyc0 - fall_cyc;
        n_checks++;
        assert (lat >= 98 && lat <= 100) else begin
            n_fail++;
            $error("FAIL latency: observed %0d clocks, required 98..100", lat);
        end
        push(0, 9'h65, 1'b0, 1'b0);
        send_frame(0, 9'h65, 8, 0, 1'b0, 1, 1'b1);
        push(0, 9'h6C, 1'b0, 1'b0);
        send_frame(0, 9'h6C, 8, 0, 1'b0, 1, 1'b1);
        push(0, 9'h6C, 1'b0, 1'b0);
        send_frame(0, 9'h6C, 8, 0, 1'b0, 1, 1'b1);
        push(0, 9'h00, 1'b0, 1'b0);
        send_frame(0, 9'h00, 8, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clock);
        check("stream pending", 32'(q0.size()), 32'(0));
        check("stream overrun", 32'(ovr_cnt0 - ovr_snap), 32'(0));

        // Parity: even then odd, parity bit 1 then 0
        push(1, 9'h55, exp_pe(2, 9'h55, 1'b1), 1'b0);
        send_frame(1, 9'h55, 8, 1, 1'b1, 1, 1'b1);
        push(1, 9'h55, exp_pe(2, 9'h55, 1'b0), 1'b0);
        send_frame(1, 9'h55, 8, 1, 1'b0, 1, 1'b1);
        push(2, 9'h55, exp_pe(1, 9'h55, 1'b1), 1'b0);
        send_frame(2, 9'h55, 8, 1, 1'b1, 1, 1'b1);
        push(2, 9'h55, exp_pe(1, 9'h55, 1'b0), 1'b0);
        send_frame(2, 9'h55, 8, 1, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clock);

        // Framing error and recovery
        push(0, 9'h3C, 1'b0, 1'b1);
        send_frame(0, 9'h3C, 8, 0, 1'b0, 1, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        push(0, 9'hA5, 1'b0, 1'b0);
        send_frame(0, 9'hA5, 8, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clock);

        // Glitch rejection
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clock);
        check("glitch busy high", 32'(busy_w[0]), 32'(1));
        rx_line[0] = 1'b1;
        repeat (8) @(negedge clock);
        check("glitch busy low", 32'(busy_w[0]), 32'(0));
        check("glitch no word", 32'(bus0.data_out_valid), 32'(0));
        repeat (10) @(negedge clock);
        push(0, 9'h81, 1'b0, 1'b0);
        send_frame(0, 9'h81, 8, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clock);

        // Backpressure
        @(posedge clock);
        #1 bus0.data_out_ready = 1'b0;
        @(negedge clock);
        ovr_snap = ovr_cnt0;
        push(0, 9'h11, 1'b0, 1'b0);
        send_frame(0, 9'h11, 8, 0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h22, 8, 0, 1'b0, 1, 1'b1);
        repeat (5) @(negedge clock);
        check("backpressure data", 32'(bus0.data_out), 32'h11);
        check("backpressure valid", 32'(bus0.data_out_valid), 32'(1));
        check("overrun pulse cycles", 32'(ovr_cnt0 - ovr_snap), 32'(1));
        @(posedge clock);
        #1 bus0.data_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("after transfer valid", 32'(bus0.data_out_valid), 32'(0));
        check("after transfer pending", 32'(q0.size()), 32'(0));

        // 7N2 configuration
        push(3, 9'h7F, 1'b0, 1'b0);
        send_frame(3, 9'h7F, 7, 0, 1'b0, 2, 1'b1);
        repeat (20) @(negedge clock);

        // Reset mid-data with the line low, released while still low
        rx_line[3] = 1'b0;
        repeat (30) @(negedge clock);
        check("mid-frame busy", 32'(busy_w[3]), 32'(1));
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("post-reset busy", 32'(busy_w[3]), 32'(0));
        check("post-reset valid", 32'(bus3.data_out_valid), 32'(0));
        rx_line[3] = 1'b1;
        repeat (20) @(negedge clock);
        check("post-reset idle busy", 32'(busy_w[3]), 32'(0));
        push(3, 9'h2A, 1'b0, 1'b0);
        send_frame(3, 9'h2A, 7, 0, 1'b0, 2, 1'b1);

        // Drain with a bound
        for (int i = 0; i < 400 && (q0.size() + q1.size() + q2.size() + q3.size()) != 0; i++)
            @(negedge clock);
        check("final pending dut0", 32'(q0.size()), 32'(0));
        check("final pending dut1", 32'(q1.size()), 32'(0));
        check("final pending dut2", 32'(q2.size()), 32'(0));
        check("final pending dut3", 32'(q3.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
